ip_packet_rx: RTL and testbench
===============================

IP_PACKET_RX -- requirements
Module: ip_packet_rx

Interface
REQ-001 Parameter AXI_S_DATA_WIDTH, default 8: MAC stream byte width.
REQ-002 Parameter IP_ADDR_WIDTH, default 32: IPv4 address width.
REQ-003 Parameter MAC_ADDR_WIDTH, default 48: MAC address width.
REQ-004 Parameter ACCEL_DATA_WIDTH, default 10: message width.
REQ-005 aclk  in  1  clock; all logic rising-edge.
REQ-006 areset  in  1  reset, asynchronous, active-high.
REQ-007 ACCELERATOR_IP_ADDRESS  in  32  own IP; ACCELERATOR_MAC_ADDRESS  in  48  own MAC.
REQ-008 MAC_DATA_IN  in  8  stream byte; MAC_DATA_VALID  in  1; MAC_DATA_FIRST  in  1  first byte of frame; MAC_DATA_LAST  in  1  last byte of frame.
REQ-009 MAC_DATA_READY  out  1  byte accepted when VALID && READY.
REQ-010 SENDER_MAC_ADDRESS  out  48; SENDER_IP_ADDRESS  out  32; SENDER_MESSAGE  out  10  fields of delivered frame.
REQ-011 MESSAGE_VALID  out  1; MESSAGE_READY  in  1  message handshake to accelerator.
REQ-012 DROP_COUNT  out  8  saturating count of discarded frames.

Function
REQ-013 Frame format SHALL be 34 bytes: dst MAC (0-5), src MAC (6-11), 20-byte IPv4 header (12-31), payload (32-33); multi-byte fields MSB first.
REQ-014 States SHALL be IDLE, RX_ETH_HDR, RX_IP_HDR, RX_USER_DATA, DELIVER, DROP; 6-bit byte counter cleared on every state change.
REQ-015 IDLE: accepted byte with FIRST=1 -> RX_ETH_HDR as byte 0; FIRST=0 bytes consumed and ignored.
REQ-016 MAC_DATA_READY SHALL be 1 in every state except DELIVER.
REQ-017 Frame accepted only if: dst MAC == ACCELERATOR_MAC_ADDRESS or FF:FF:FF:FF:FF:FF; byte 12 == 0x45; total length (bytes 14-15) == 36; dst IP (bytes 28-31) == ACCELERATOR_IP_ADDRESS; header checksum valid.
REQ-018 Checksum: 16-bit ones-complement sum of the ten header words with end-around carry; valid iff result == 0xFFFF after byte 31.
REQ-019 Any check failure SHALL take the FSM to DROP on the cycle after the failing byte; DROP consumes bytes until LAST accepted, then IDLE.
REQ-020 SENDER_MESSAGE = {byte32[1:0], byte33}; byte32[7:2] ignored.
REQ-021 Byte 33 SHALL carry LAST; if not, frame -> DROP; LAST on any byte before 33 -> IDLE, frame counted as dropped.
REQ-022 FIRST=1 on a byte accepted outside IDLE/DROP SHALL abort current frame (counted dropped) and restart at RX_ETH_HDR byte 0.
REQ-023 After valid byte 33 accepted, MESSAGE_VALID SHALL assert next cycle (1-cycle latency) in DELIVER with all SENDER_* registered and stable.
REQ-024 DELIVER holds until MESSAGE_VALID && MESSAGE_READY, then IDLE next cycle; MESSAGE_VALID never drops without handshake.
REQ-025 DROP_COUNT increments once per discarded frame, saturates at 0xFF, never wraps.

Reset
REQ-026 areset SHALL force state IDLE, counter 0, checksum 0, MESSAGE_VALID 0, SENDER_* 0, DROP_COUNT 0, MAC_DATA_READY 1 after release; mid-frame reset discards frame without counting.

Structure
REQ-027 Package ip_packet_pkg SHALL hold the state enum, byte offsets, header lengths (12, 20), IP_VERSION_IHL 0x45, PACKET_LENGTH 36, BROADCAST_MAC; shared with the transmitter.
REQ-028 Checksum SHALL be sub-module ones_complement_accumulator (clear, byte-valid, byte in, 16-bit sum out).

Verification
REQ-029 Own MAC 02:00:00:00:00:01, IP 0x0A000002; valid frame from 0x0A000001, message 0x2A5 -> MESSAGE_VALID one cycle after byte 33, SENDER_MESSAGE 0x2A5, SENDER_IP 0x0A000001.
REQ-030 Same frame, dst MAC 02:00:00:00:00:09 -> no MESSAGE_VALID, DROP_COUNT 0->1, next valid frame delivered.
REQ-031 Header checksum bytes corrupted by 1 -> dropped, DROP_COUNT +1; broadcast dst MAC with good checksum -> delivered.
REQ-032 LAST on byte 20 -> IDLE, DROP_COUNT +1; FIRST on byte 15 -> restart, following 34 bytes delivered.
REQ-033 MESSAGE_READY held 0 for 5 cycles -> MESSAGE_VALID and SENDER_* stable, MAC_DATA_READY 0 throughout, released on handshake.
REQ-034 areset pulsed at byte 25 -> all outputs zero, DROP_COUNT unchanged at 0, next frame delivered.

Source files
------------

// File: rtl/ip_packet_pkg.sv
// Shared definitions for the IPv4/UDP-style accelerator frame path (receiver and transmitter).
// Offsets are absolute byte positions within the 34-byte frame.
package ip_packet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_ETH_HDR,
        RX_IP_HDR,
        RX_USER_DATA,
        DELIVER,
        DROP
    } rx_state_t;

    localparam logic [5:0]  ETH_HDR_LEN    = 6'd12;
    localparam logic [5:0]  IP_HDR_LEN     = 6'd20;

    localparam logic [5:0]  DST_MAC_OFS    = 6'd0;
    localparam logic [5:0]  SRC_MAC_OFS    = 6'd6;
    localparam logic [5:0]  IP_HDR_OFS     = ETH_HDR_LEN;
    localparam logic [5:0]  TOTAL_LEN_OFS  = 6'd14;
    localparam logic [5:0]  SRC_IP_OFS     = 6'd24;
    localparam logic [5:0]  DST_IP_OFS     = 6'd28;
    localparam logic [5:0]  USER_DATA_OFS  = IP_HDR_OFS + IP_HDR_LEN;
    localparam logic [5:0]  LAST_BYTE_OFS  = USER_DATA_OFS + 6'd1;

    localparam logic [7:0]  IP_VERSION_IHL = 8'h45;
    localparam logic [15:0] PACKET_LENGTH  = 16'd36;
    localparam logic [15:0] CHECKSUM_OK    = 16'hFFFF;
    localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/ones_complement_accumulator.sv
// Byte-serial 16-bit ones-complement adder for IPv4 header checksums.
// Bytes alternate high/low within each word, starting high after a clear.
module ones_complement_accumulator (
    input  logic        aclk,
    input  logic        areset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_sum
);

    logic [15:0] r_sum;
    logic        r_low_phase;
    logic [15:0] w_addend;
    logic [16:0] w_raw;
    logic [15:0] w_folded;

    // o_sum already includes the byte on i_byte so the final word can be judged on its own cycle
    always_comb begin
        w_addend = r_low_phase ? {8'h00, i_byte} : {i_byte, 8'h00};
        w_raw    = {1'b0, r_sum} + {1'b0, w_addend};
        w_folded = w_raw[15:0] + {15'd0, w_raw[16]};
        o_sum    = i_valid ? w_folded : r_sum;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sum       <= 16'd0;
            r_low_phase <= 1'b0;
        end else if (i_clear) begin
            r_sum       <= 16'd0;
            r_low_phase <= 1'b0;
        end else if (i_valid) begin
            r_sum       <= w_folded;
            r_low_phase <= ~r_low_phase;
        end
    end

endmodule

// File: rtl/ip_packet_rx.sv
// Receives 34-byte Ethernet/IPv4 frames from the MAC, filters them by address, length and
// header checksum, and hands the 10-bit payload message to the accelerator.
module ip_packet_rx
    import ip_packet_pkg::*;
#(
    parameter int AXI_S_DATA_WIDTH = 8,
    parameter int IP_ADDR_WIDTH    = 32,
    parameter int MAC_ADDR_WIDTH   = 48,
    parameter int ACCEL_DATA_WIDTH = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
    input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
    input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
    input  logic                        MAC_DATA_VALID,
    input  logic                        MAC_DATA_FIRST,
    input  logic                        MAC_DATA_LAST,
    output logic                        MAC_DATA_READY,
    output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
    output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
    output logic [ACCEL_DATA_WIDTH-1:0] SENDER_MESSAGE,
    output logic                        MESSAGE_VALID,
    input  logic                        MESSAGE_READY,
    output logic [7:0]                  DROP_COUNT
);

    rx_state_t r_state;
    rx_state_t w_state_next;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_next;

    logic                      r_own_ok;
    logic                      r_bc_ok;
    logic [MAC_ADDR_WIDTH-1:0] r_src_mac_cap;
    logic [IP_ADDR_WIDTH-1:0]  r_src_ip_cap;
    logic [1:0]                r_msg_hi;
    logic [7:0]                r_drop_count;

    logic        w_accept;
    logic        w_in_frame;
    logic        w_frame_byte;
    logic [5:0]  w_pos;
    logic [5:0]  w_mac_lsb;
    logic [4:0]  w_ip_lsb;
    logic        w_own_ok;
    logic        w_bc_ok;
    logic        w_fail;
    logic        w_csum_valid;
    logic [15:0] w_csum;
    logic [1:0]  w_drop_inc;
    logic [8:0]  w_drop_sum;

    assign MAC_DATA_READY = (r_state != DELIVER);
    assign MESSAGE_VALID  = (r_state == DELIVER);
    assign DROP_COUNT     = r_drop_count;
    assign w_accept       = MAC_DATA_VALID && MAC_DATA_READY;
    assign w_frame_byte   = w_accept && w_in_frame;

    // A FIRST byte always becomes position 0 of a new frame, whatever state it lands in
    always_comb begin
        w_in_frame = 1'b0;
        w_pos      = 6'd0;
        case (r_state)
            IDLE:         w_in_frame = MAC_DATA_FIRST;
            RX_ETH_HDR: begin
                w_in_frame = 1'b1;
                w_pos      = MAC_DATA_FIRST ? 6'd0 : r_cnt;
            end
            RX_IP_HDR: begin
                w_in_frame = 1'b1;
                w_pos      = MAC_DATA_FIRST ? 6'd0 : IP_HDR_OFS + r_cnt;
            end
            RX_USER_DATA: begin
                w_in_frame = 1'b1;
                w_pos      = MAC_DATA_FIRST ? 6'd0 : USER_DATA_OFS + r_cnt;
            end
            default:      w_in_frame = 1'b0;
        endcase
    end

    assign w_csum_valid = w_frame_byte && (w_pos >= IP_HDR_OFS) && (w_pos < USER_DATA_OFS);

    ones_complement_accumulator u_csum (
        .aclk    (aclk),
        .areset  (areset),
        .i_clear (w_frame_byte && (w_pos == DST_MAC_OFS)),
        .i_valid (w_csum_valid),
        .i_byte  (MAC_DATA_IN),
        .o_sum   (w_csum)
    );

    // Per-byte header checks; the destination MAC is matched incrementally against both candidates
    always_comb begin
        w_mac_lsb = {3'd5 - w_pos[2:0], 3'b000};
        w_ip_lsb  = {2'd3 - w_pos[1:0], 3'b000};
        w_own_ok  = (w_pos == DST_MAC_OFS || r_own_ok)
                    && (MAC_DATA_IN == ACCELERATOR_MAC_ADDRESS[w_mac_lsb +: 8]);
        w_bc_ok   = (w_pos == DST_MAC_OFS || r_bc_ok) && (MAC_DATA_IN == BROADCAST_MAC[7:0]);
        w_fail    = 1'b0;
        if (w_pos < SRC_MAC_OFS)
            w_fail = !(w_own_ok || w_bc_ok);
        if (w_pos == IP_HDR_OFS)
            w_fail = (MAC_DATA_IN != IP_VERSION_IHL);
        if (w_pos == TOTAL_LEN_OFS)
            w_fail = (MAC_DATA_IN != PACKET_LENGTH[15:8]);
        if (w_pos == TOTAL_LEN_OFS + 6'd1)
            w_fail = (MAC_DATA_IN != PACKET_LENGTH[7:0]);
        if (w_pos >= DST_IP_OFS && w_pos < USER_DATA_OFS)
            w_fail = (MAC_DATA_IN != ACCELERATOR_IP_ADDRESS[w_ip_lsb +: 8]);
        if (w_pos == USER_DATA_OFS - 6'd1 && w_csum != CHECKSUM_OK)
            w_fail = 1'b1;
    end

    // r_cnt indexes the next byte expected within the current state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_drop_inc   = 2'd0;
        case (r_state)
            IDLE, RX_ETH_HDR, RX_IP_HDR, RX_USER_DATA: begin
                if (w_accept && MAC_DATA_FIRST && r_state != IDLE)
                    w_drop_inc = 2'd1;
                if (w_frame_byte) begin
                    w_cnt_next = 6'd0;
                    if (w_pos == LAST_BYTE_OFS) begin
                        if (MAC_DATA_LAST) begin
                            w_state_next = DELIVER;
                        end else begin
                            w_state_next = DROP;
                            w_drop_inc   = w_drop_inc + 2'd1;
                        end
                    end else if (MAC_DATA_LAST) begin
                        w_state_next = IDLE;
                        w_drop_inc   = w_drop_inc + 2'd1;
                    end else if (w_fail) begin
                        w_state_next = DROP;
                        w_drop_inc   = w_drop_inc + 2'd1;
                    end else if (w_pos < IP_HDR_OFS - 6'd1) begin
                        w_state_next = RX_ETH_HDR;
                        w_cnt_next   = w_pos + 6'd1;
                    end else if (w_pos < USER_DATA_OFS - 6'd1) begin
                        w_state_next = RX_IP_HDR;
                        w_cnt_next   = w_pos + 6'd1 - IP_HDR_OFS;
                    end else begin
                        w_state_next = RX_USER_DATA;
                        w_cnt_next   = w_pos + 6'd1 - USER_DATA_OFS;
                    end
                end
            end
            DELIVER: begin
                if (MESSAGE_READY) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 6'd0;
                end
            end
            DROP: begin
                if (w_accept && MAC_DATA_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 6'd0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 6'd0;
            end
        endcase
    end

    assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_drop_inc};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= IDLE;
            r_cnt        <= 6'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // Fields are captured into shadow registers so SENDER_* only change when a frame is delivered
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_own_ok           <= 1'b0;
            r_bc_ok            <= 1'b0;
            r_src_mac_cap      <= '0;
            r_src_ip_cap       <= '0;
            r_msg_hi           <= 2'd0;
            SENDER_MAC_ADDRESS <= '0;
            SENDER_IP_ADDRESS  <= '0;
            SENDER_MESSAGE     <= '0;
        end else if (w_frame_byte) begin
            if (w_pos < SRC_MAC_OFS) begin
                r_own_ok <= w_own_ok;
                r_bc_ok  <= w_bc_ok;
            end
            if (w_pos >= SRC_MAC_OFS && w_pos < IP_HDR_OFS)
                r_src_mac_cap <= {r_src_mac_cap[MAC_ADDR_WIDTH-9:0], MAC_DATA_IN};
            if (w_pos >= SRC_IP_OFS && w_pos < DST_IP_OFS)
                r_src_ip_cap <= {r_src_ip_cap[IP_ADDR_WIDTH-9:0], MAC_DATA_IN};
            if (w_pos == USER_DATA_OFS)
                r_msg_hi <= MAC_DATA_IN[1:0];
            if (w_pos == LAST_BYTE_OFS && MAC_DATA_LAST) begin
                SENDER_MAC_ADDRESS <= r_src_mac_cap;
                SENDER_IP_ADDRESS  <= r_src_ip_cap;
                SENDER_MESSAGE     <= {r_msg_hi, MAC_DATA_IN};
            end
        end
    end

endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed bench for ip_packet_rx: hand-built frames, expected fields and drop counts as constants.
`timescale 1ns/1ps
module tb_ip_packet_rx;

    localparam logic [47:0] OWN_MAC    = 48'h02_00_00_00_00_01;
    localparam logic [31:0] OWN_IP     = 32'h0A_00_00_02;
    localparam logic [47:0] EXP_SRCMAC = 48'h02_00_00_00_00_AA;
    localparam logic [31:0] EXP_SRCIP  = 32'h0A_00_00_01;
    localparam logic [9:0]  EXP_MSG    = 10'h2A5;

    logic        aclk;
    logic        areset;
    logic [7:0]  MAC_DATA_IN;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_FIRST;
    logic        MAC_DATA_LAST;
    logic        MAC_DATA_READY;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [9:0]  SENDER_MESSAGE;
    logic        MESSAGE_VALID;
    logic        MESSAGE_READY;
    logic [7:0]  DROP_COUNT;

    int n_checks = 0;
    int n_errors = 0;
    int exp_drop = 0;

    // Header checksum hand-computed: ~(4500+0024+4011+0A00+0001+0A00+0002) = ~9938 = 66C7
    logic [7:0] good [34] = '{
        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA,
        8'h45, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h40, 8'h11, 8'h66, 8'hC7,
        8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
        8'hFE, 8'hA5
    };
    logic [7:0] frm [34];

    int         bad_idx [6] = '{5, 23, 12, 15, 31, 0};
    logic [7:0] bad_val [6] = '{8'h09, 8'hC8, 8'h46, 8'h25, 8'h03, 8'hFF};

    ip_packet_rx dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .ACCELERATOR_IP_ADDRESS  (OWN_IP),
        .ACCELERATOR_MAC_ADDRESS (OWN_MAC),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_FIRST          (MAC_DATA_FIRST),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
        .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
        .SENDER_MESSAGE          (SENDER_MESSAGE),
        .MESSAGE_VALID           (MESSAGE_VALID),
        .MESSAGE_READY           (MESSAGE_READY),
        .DROP_COUNT              (DROP_COUNT)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic load_good();
        for (int i = 0; i < 34; i++) frm[i] = good[i];
    endtask

    task automatic send_byte(input logic [7:0] d, input logic f, input logic l);
        MAC_DATA_IN    = d;
        MAC_DATA_FIRST = f;
        MAC_DATA_LAST  = l;
        MAC_DATA_VALID = 1'b1;
        @(posedge aclk);
        #1;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_FIRST = 1'b0;
        MAC_DATA_LAST  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input logic with_last);
        for (int i = lo; i <= hi; i++)
            send_byte(frm[i], i == lo, with_last && (i == hi));
    endtask

    task automatic handshake(input string tag);
        MESSAGE_READY = 1'b1;
        @(posedge aclk);
        #1;
        MESSAGE_READY = 1'b0;
        check_eq({tag, "_valid_after_hs"}, MESSAGE_VALID, 1'b0);
        check_eq({tag, "_ready_after_hs"}, MAC_DATA_READY, 1'b1);
    endtask

    task automatic expect_delivery(input string tag);
        check_eq({tag, "_msg_valid"}, MESSAGE_VALID, 1'b1);
        check_eq({tag, "_mac_ready"}, MAC_DATA_READY, 1'b0);
        check_eq({tag, "_message"}, SENDER_MESSAGE, EXP_MSG);
        check_eq({tag, "_sender_ip"}, SENDER_IP_ADDRESS, EXP_SRCIP);
        check_eq({tag, "_sender_mac"}, SENDER_MAC_ADDRESS, EXP_SRCMAC);
        check_eq({tag, "_drop_count"}, DROP_COUNT, exp_drop[7:0]);
        handshake(tag);
    endtask

    task automatic expect_drop(input string tag);
        exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        check_eq({tag, "_no_msg"}, MESSAGE_VALID, 1'b0);
        check_eq({tag, "_drop_count"}, DROP_COUNT, exp_drop[7:0]);
    endtask

    initial begin
        areset         = 1'b1;
        MAC_DATA_IN    = 8'h00;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_FIRST = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MESSAGE_READY  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;

        check_eq("rst_msg_valid", MESSAGE_VALID, 1'b0);
        check_eq("rst_mac_ready", MAC_DATA_READY, 1'b1);
        check_eq("rst_drop_count", DROP_COUNT, 8'h00);
        check_eq("rst_sender_msg", SENDER_MESSAGE, 10'h000);
        check_eq("rst_sender_ip", SENDER_IP_ADDRESS, 32'h0);

        // Byte without FIRST in IDLE is consumed and ignored
        send_byte(8'h55, 1'b0, 1'b0);
        check_eq("stray_drop_count", DROP_COUNT, 8'h00);

        // Valid frame: no message until byte 33, then exactly one cycle later
        load_good();
        send_range(0, 32, 1'b0);
        check_eq("good_before_b33", MESSAGE_VALID, 1'b0);
        send_byte(frm[33], 1'b0, 1'b1);
        expect_delivery("good");

        // Table of single-byte corruptions that must each discard the frame
        for (int k = 0; k < 6; k++) begin
            load_good();
            frm[bad_idx[k]] = bad_val[k];
            send_range(0, 33, 1'b1);
            expect_drop($sformatf("bad_b%0d", bad_idx[k]));
        end

        load_good();
        send_range(0, 33, 1'b1);
        expect_delivery("after_drops");

        // Broadcast destination accepted
        load_good();
        for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
        send_range(0, 33, 1'b1);
        expect_delivery("broadcast");

        // Early LAST on byte 20
        load_good();
        send_range(0, 20, 1'b1);
        expect_drop("last_b20");
        check_eq("last_b20_ready", MAC_DATA_READY, 1'b1);
        send_range(0, 33, 1'b1);
        expect_delivery("after_last_b20");

        // FIRST arriving at byte 15 aborts and restarts
        send_range(0, 14, 1'b0);
        send_range(0, 33, 1'b1);
        exp_drop++;
        expect_delivery("restart_b15");

        // Byte 33 without LAST drops; an extra LAST byte returns to IDLE
        send_range(0, 33, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        expect_drop("no_last_b33");
        send_range(0, 33, 1'b1);
        expect_delivery("after_no_last");

        // Accelerator back-pressure for 5 cycles
        send_range(0, 33, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk);
            #1;
            check_eq($sformatf("stall%0d_valid", c), MESSAGE_VALID, 1'b1);
            check_eq($sformatf("stall%0d_msg", c), SENDER_MESSAGE, EXP_MSG);
            check_eq($sformatf("stall%0d_ip", c), SENDER_IP_ADDRESS, EXP_SRCIP);
            check_eq($sformatf("stall%0d_ready", c), MAC_DATA_READY, 1'b0);
        end
        expect_delivery("stall_release");

        // Drop counter saturates: 260 one-byte frames
        for (int n = 0; n < 260; n++) send_byte(8'h02, 1'b1, 1'b1);
        exp_drop = 255;
        check_eq("sat_drop_count", DROP_COUNT, 8'hFF);
        send_byte(8'h02, 1'b1, 1'b1);
        check_eq("sat_no_wrap", DROP_COUNT, 8'hFF);
        send_range(0, 33, 1'b1);
        expect_delivery("after_sat");

        // Asynchronous reset mid-frame at byte 25
        send_range(0, 24, 1'b0);
        #2;
        areset = 1'b1;
        #2;
        check_eq("arst_msg_valid", MESSAGE_VALID, 1'b0);
        check_eq("arst_sender_msg", SENDER_MESSAGE, 10'h000);
        check_eq("arst_sender_ip", SENDER_IP_ADDRESS, 32'h0);
        check_eq("arst_sender_mac", SENDER_MAC_ADDRESS, 48'h0);
        check_eq("arst_drop_count", DROP_COUNT, 8'h00);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_drop = 0;
        check_eq("arst_mac_ready", MAC_DATA_READY, 1'b1);
        send_range(0, 33, 1'b1);
        expect_delivery("after_arst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
